// File: rtl/cal_frame_sweeper.sv
// Calibration frame sweeper: after each ID bit is on the LED strand and the camera has settled,
// reads the whole frame buffer once, thresholds each pixel and streams the bits downstream.
// Optional macro CAL_SWEEP_AUTO_RUN_EN: one start_capture chains all ID-bit sweeps.
module cal_frame_sweeper #(
   parameter int                     NUM_FRAME_BUFFER_PIXELS = 360*180,
   parameter int                     PIXEL_WIDTH             = 16,
   parameter logic [PIXEL_WIDTH-1:0] THRESHOLD               = 16'hFFF0,
   parameter int                     LED_ADDRESS_WIDTH       = 10,
   parameter int                     SETTLE_FRAMES           = 2,
   localparam int                    CNT_W                   = $clog2(NUM_FRAME_BUFFER_PIXELS),
   localparam int                    BI_W                    = LED_ADDRESS_WIDTH + 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   calibration_on,
   input  logic                   start_capture,
   input  logic                   displayed_frame_valid,
   input  logic                   camera_frame_done,
   output logic [CNT_W-1:0]       fb_read_addr,
   input  logic [PIXEL_WIDTH-1:0] fb_read_data,
   output logic [CNT_W-1:0]       frame_buffer_in_address,
   output logic                   frame_buffer_data,
   output logic                   new_frame_address,
   output logic                   increment_id,
   output logic [BI_W-1:0]        bit_index,
   output logic                   busy,
   output logic                   cal_done
);

   // state        | meaning
   // S_IDLE       | waiting for start_capture with calibration_on
   // S_WAIT_SHOWN | waiting for the strand to show the current ID bit
   // S_SETTLE     | counting camera frames so the exposure reflects the new bit
   // S_SWEEP      | issuing one frame-buffer read address per cycle
   // S_DRAIN      | three cycles flushing the read/threshold pipeline
   // S_ADVANCE    | one-cycle increment_id pulse, bit_index bumped
   // S_DONE       | all ID bits captured, cal_done held
   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_SHOWN,
      S_SETTLE,
      S_SWEEP,
      S_DRAIN,
      S_ADVANCE,
      S_DONE
   } state_e;

   localparam int               NUM_BITS  = LED_ADDRESS_WIDTH + 1;
   localparam int               SET_W     = $clog2(SETTLE_FRAMES + 1);
   localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(NUM_FRAME_BUFFER_PIXELS - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] addr_q, addr_d;
   logic [SET_W-1:0] settle_q, settle_d;
   logic [SET_W-1:0] settle_inc;
   logic [1:0]       drain_q, drain_d;
   logic [BI_W-1:0]  bit_index_q, bit_index_d;
   logic             wait_go;

   logic             p1_vld_q, p2_vld_q, out_vld_q;
   logic [CNT_W-1:0] p1_addr_q, p2_addr_q, out_addr_q;
   logic             out_bit_q;

`ifdef CAL_SWEEP_AUTO_RUN_EN
   // After an ADVANCE the previous bit may still report valid; only a fresh rising edge counts.
   logic dfv_prev_q, edge_req_q, edge_req_d;

   always_comb begin
      edge_req_d = edge_req_q;
      if (state_q == S_ADVANCE) begin
         edge_req_d = 1'b1;
      end else if (state_q == S_IDLE) begin
         edge_req_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dfv_prev_q <= 1'b0;
         edge_req_q <= 1'b0;
      end else begin
         dfv_prev_q <= displayed_frame_valid;
         edge_req_q <= edge_req_d;
      end
   end

   assign wait_go = edge_req_q ? (displayed_frame_valid & ~dfv_prev_q) : displayed_frame_valid;
`else
   assign wait_go = displayed_frame_valid;
`endif

   assign settle_inc = settle_q + SET_W'(1);

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      settle_d    = settle_q;
      drain_d     = drain_q;
      bit_index_d = bit_index_q;
      if (!calibration_on) begin
         state_d     = S_IDLE;
         bit_index_d = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start_capture) begin
                  state_d = S_WAIT_SHOWN;
               end
            end
            S_WAIT_SHOWN: begin
               if (wait_go) begin
                  state_d  = S_SETTLE;
                  settle_d = '0;
               end
            end
            S_SETTLE: begin
               if (camera_frame_done) begin
                  settle_d = settle_inc;
                  if (settle_inc == SET_W'(SETTLE_FRAMES)) begin
                     state_d = S_SWEEP;
                     addr_d  = '0;
                  end
               end
            end
            S_SWEEP: begin
               // Stop at the last pixel rather than relying on wrap, so any pixel count works.
               if (addr_q == LAST_ADDR) begin
                  state_d = S_DRAIN;
                  drain_d = 2'd2;
               end else begin
                  addr_d = addr_q + CNT_W'(1);
               end
            end
            S_DRAIN: begin
               if (drain_q == 2'd0) begin
                  state_d     = S_ADVANCE;
                  bit_index_d = bit_index_q + BI_W'(1);
               end else begin
                  drain_d = drain_q - 2'd1;
               end
            end
            S_ADVANCE: begin
               if (bit_index_q == BI_W'(NUM_BITS)) begin
                  state_d = S_DONE;
               end else begin
`ifdef CAL_SWEEP_AUTO_RUN_EN
                  state_d = S_WAIT_SHOWN;
`else
                  state_d = S_IDLE;
`endif
               end
            end
            S_DONE: begin
               state_d = S_DONE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         settle_q    <= '0;
         drain_q     <= '0;
         bit_index_q <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         settle_q    <= settle_d;
         drain_q     <= drain_d;
         bit_index_q <= bit_index_d;
      end
   end

   // Read data arrives two cycles after the address; the registered result lands on the third.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p1_vld_q   <= 1'b0;
         p2_vld_q   <= 1'b0;
         out_vld_q  <= 1'b0;
         p1_addr_q  <= '0;
         p2_addr_q  <= '0;
         out_addr_q <= '0;
         out_bit_q  <= 1'b0;
      end else begin
         p1_vld_q  <= (state_q == S_SWEEP) && calibration_on;
         p2_vld_q  <= p1_vld_q && calibration_on;
         out_vld_q <= p2_vld_q && calibration_on;
         p1_addr_q <= addr_q;
         p2_addr_q <= p1_addr_q;
         if (p2_vld_q) begin
            out_addr_q <= p2_addr_q;
         end
         out_bit_q <= p2_vld_q && (fb_read_data > THRESHOLD);
      end
   end

   assign fb_read_addr            = addr_q;
   assign frame_buffer_in_address = out_addr_q;
   assign frame_buffer_data       = out_bit_q;
   assign new_frame_address       = out_vld_q;
   assign increment_id            = (state_q == S_ADVANCE) && calibration_on;
   assign bit_index               = bit_index_q;
   assign busy                    = (state_q != S_IDLE) && (state_q != S_DONE);
   assign cal_done                = (state_q == S_DONE);

endmodule

// File: tb/tb_cal_frame_sweeper.sv
// Bench for cal_frame_sweeper with a 16-pixel frame, 3 ID bits and a 2-frame settle.
// Reference: every sweep must emit addresses 0..15 in order, bit = pixel > FFF0, 3 cycles after issue.
module tb_cal_frame_sweeper;
   localparam int N  = 16;
   localparam int NB = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        calibration_on = 1'b0;
   logic        start_capture = 1'b0;
   logic        displayed_frame_valid = 1'b0;
   logic        camera_frame_done = 1'b0;
   logic [3:0]  fb_read_addr;
   logic [15:0] fb_read_data = 16'h0;
   logic [3:0]  frame_buffer_in_address;
   logic        frame_buffer_data;
   logic        new_frame_address;
   logic        increment_id;
   logic [2:0]  bit_index;
   logic        busy;
   logic        cal_done;

   cal_frame_sweeper #(
      .NUM_FRAME_BUFFER_PIXELS(N),
      .PIXEL_WIDTH(16),
      .THRESHOLD(16'hFFF0),
      .LED_ADDRESS_WIDTH(2),
      .SETTLE_FRAMES(2)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .calibration_on(calibration_on),
      .start_capture(start_capture),
      .displayed_frame_valid(displayed_frame_valid),
      .camera_frame_done(camera_frame_done),
      .fb_read_addr(fb_read_addr),
      .fb_read_data(fb_read_data),
      .frame_buffer_in_address(frame_buffer_in_address),
      .frame_buffer_data(frame_buffer_data),
      .new_frame_address(new_frame_address),
      .increment_id(increment_id),
      .bit_index(bit_index),
      .busy(busy),
      .cal_done(cal_done)
   );

   always #5 clk = ~clk;

   // Camera frame buffer: two-cycle read latency
   logic [15:0] mem [N];
   logic [3:0]  rd_a1 = 4'h0;
   always @(posedge clk) begin
      rd_a1        <= fb_read_addr;
      fb_read_data <= mem[rd_a1];
   end

   // Monitor on the falling edge
   logic [3:0] sa[$];
   logic       sd[$];
   int         lat_err = 0;
   int         inc_cnt = 0;
   logic [3:0] hist [8];
   logic [2:0] hptr = 3'd0;
   always @(negedge clk) begin
      hist[hptr] = fb_read_addr;
      if (new_frame_address) begin
         sa.push_back(frame_buffer_in_address);
         sd.push_back(frame_buffer_data);
         if (hist[hptr - 3'd3] !== frame_buffer_in_address) lat_err++;
      end
      if (increment_id) inc_cnt++;
      hptr = hptr + 3'd1;
   end

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon;
      sa.delete();
      sd.delete();
      lat_err = 0;
      inc_cnt = 0;
   endtask

   task automatic pulse_cfd;
      camera_frame_done = 1'b1;
      tick;
      camera_frame_done = 1'b0;
   endtask

   function automatic logic exp_bit(input int a);
      return mem[a] > 16'hFFF0;
   endfunction

   task automatic fill_random;
      for (int i = 0; i < N; i++) begin
         if ($urandom_range(0, 2) == 0) mem[i] = 16'hFFEE + 16'($urandom_range(0, 17));
         else mem[i] = 16'($urandom);
      end
   endtask

   task automatic verify_strobes(input string tag, input int nexp);
      int bad_a;
      int bad_d;
      bad_a = 0;
      bad_d = 0;
      check({tag, "_count"}, sa.size(), nexp);
      foreach (sa[i]) begin
         if (int'(sa[i]) != i % N) bad_a++;
         if (sd[i] !== exp_bit(i % N)) bad_d++;
      end
      check({tag, "_addr_seq"}, bad_a, 0);
      check({tag, "_data"}, bad_d, 0);
      check({tag, "_latency"}, lat_err, 0);
   endtask

   // Full capture with a stray start_capture in SETTLE and a stray frame_done in SWEEP
   task automatic do_capture(input string tag, input bit expect_sweep);
      int i;
      clear_mon;
      displayed_frame_valid = 1'b1;
      start_capture = 1'b1;
      tick;
      start_capture = 1'b0;
      repeat ($urandom_range(1, 4)) tick;
      pulse_cfd;
      repeat ($urandom_range(0, 4)) tick;
      start_capture = 1'b1;
      tick;
      start_capture = 1'b0;
      repeat ($urandom_range(0, 3)) tick;
      pulse_cfd;
      repeat (4) tick;
      pulse_cfd;
      i = 0;
      while (i < 60 && inc_cnt == 0) begin
         tick;
         i++;
      end
      repeat (3) tick;
      if (expect_sweep) check({tag, "_timeout"}, 32'(inc_cnt != 0), 1);
   endtask

   task automatic begin_sweep;
      displayed_frame_valid = 1'b1;
      start_capture = 1'b1;
      tick;
      start_capture = 1'b0;
      tick;
      pulse_cfd;
      tick;
      pulse_cfd;
   endtask

   task automatic wait_addr(input string tag, input logic [3:0] a);
      int i;
      i = 0;
      while (i < 40 && !(busy && fb_read_addr == a)) begin
         tick;
         i++;
      end
      check({tag, "_reach_addr"}, 32'(busy && fb_read_addr == a), 1);
   endtask

   initial begin
      for (int i = 0; i < 8; i++) hist[i] = 4'h0;
      for (int i = 0; i < N; i++) mem[i] = 16'h0;
      repeat (3) tick;
      check("rst_strobe", 32'(new_frame_address), 0);
      check("rst_inc", 32'(increment_id), 0);
      check("rst_bit_index", 32'(bit_index), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_cal_done", 32'(cal_done), 0);
      check("rst_fb_addr", 32'(fb_read_addr), 0);
      check("rst_fb_in_addr", 32'(frame_buffer_in_address), 0);
      check("rst_fb_data", 32'(frame_buffer_data), 0);
      rst_n = 1'b1;
      tick;
      calibration_on = 1'b1;
      tick;

`ifndef CAL_SWEEP_AUTO_RUN_EN
      mem[3] = 16'hFFF0;
      mem[4] = 16'hFFF1;
      do_capture("sweep1", 1'b1);
      verify_strobes("sweep1", N);
      if (sa.size() == N) begin
         check("thr_at_fff0", 32'(sd[3]), 0);
         check("thr_at_fff1", 32'(sd[4]), 1);
      end
      check("sweep1_inc", inc_cnt, 1);
      check("sweep1_bit_index", 32'(bit_index), 1);
      check("sweep1_busy", 32'(busy), 0);
      check("sweep1_cal_done", 32'(cal_done), 0);

      for (int s = 2; s <= NB; s++) begin
         fill_random;
         do_capture($sformatf("sweep%0d", s), 1'b1);
         verify_strobes($sformatf("sweep%0d", s), N);
         check($sformatf("sweep%0d_bit_index", s), 32'(bit_index), s);
      end
      check("done_cal_done", 32'(cal_done), 1);
      check("done_busy", 32'(busy), 0);

      do_capture("extra", 1'b0);
      check("extra_strobes", sa.size(), 0);
      check("extra_inc", inc_cnt, 0);
      check("extra_bit_index", 32'(bit_index), NB);
      check("extra_cal_done", 32'(cal_done), 1);

      calibration_on = 1'b0;
      repeat (2) tick;
      check("calon_clr_done", 32'(cal_done), 0);
      check("calon_clr_bit_index", 32'(bit_index), 0);
      calibration_on = 1'b1;
      tick;

      fill_random;
      do_capture("pre_abort", 1'b1);
      verify_strobes("pre_abort", N);
      check("pre_abort_bit_index", 32'(bit_index), 1);

      clear_mon;
      begin_sweep;
      wait_addr("abort", 4'd4);
      calibration_on = 1'b0;
      repeat (20) tick;
      check("abort_count_le5", 32'(sa.size() <= 5), 1);
      begin
         int bad;
         bad = 0;
         foreach (sa[i]) if (int'(sa[i]) != i) bad++;
         check("abort_addr_seq", bad, 0);
      end
      check("abort_inc", inc_cnt, 0);
      check("abort_bit_index", 32'(bit_index), 0);
      check("abort_busy", 32'(busy), 0);
      calibration_on = 1'b1;
      tick;

      do_capture("pre_reset", 1'b1);
      check("pre_reset_bit_index", 32'(bit_index), 1);
      clear_mon;
      begin_sweep;
      wait_addr("arst", 4'd6);
      rst_n = 1'b0;
      #1;
      check("arst_strobe", 32'(new_frame_address), 0);
      check("arst_busy", 32'(busy), 0);
      check("arst_fb_addr", 32'(fb_read_addr), 0);
      check("arst_bit_index", 32'(bit_index), 0);
      tick;
      rst_n = 1'b1;
      tick;
`else
      fill_random;
      clear_mon;
      displayed_frame_valid = 1'b1;
      start_capture = 1'b1;
      tick;
      start_capture = 1'b0;
      begin
         int seen;
         int lowcnt;
         seen = 0;
         lowcnt = 0;
         for (int i = 0; i < 600 && !cal_done; i++) begin
            camera_frame_done = (i % 5 == 0);
            if (inc_cnt != seen) begin
               seen = inc_cnt;
               displayed_frame_valid = 1'b0;
               lowcnt = 2;
            end else if (lowcnt > 0) begin
               lowcnt--;
               if (lowcnt == 0) displayed_frame_valid = 1'b1;
            end
            tick;
         end
         camera_frame_done = 1'b0;
      end
      repeat (3) tick;
      verify_strobes("auto", NB * N);
      check("auto_inc", inc_cnt, NB);
      check("auto_cal_done", 32'(cal_done), 1);
      check("auto_bit_index", 32'(bit_index), NB);

      calibration_on = 1'b0;
      repeat (2) tick;
      calibration_on = 1'b1;
      tick;
      clear_mon;
      displayed_frame_valid = 1'b1;
      start_capture = 1'b1;
      tick;
      start_capture = 1'b0;
      for (int i = 0; i < 150; i++) begin
         camera_frame_done = (i % 5 == 0);
         tick;
      end
      camera_frame_done = 1'b0;
      verify_strobes("stall", N);
      check("stall_inc", inc_cnt, 1);
      check("stall_busy", 32'(busy), 1);
      check("stall_bit_index", 32'(bit_index), 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/cal_frame_sweeper.md
Name: cal_frame_sweeper

Overview:
- Upstream feeder of the calibration manager.
- On a user capture request, waits until the LED strand shows the current ID bit, then lets the camera settle for a set number of frames.
- Then sweeps every camera frame-buffer pixel once, thresholds it, and streams address / bit / strobe into the calibration table update path.
- After each sweep it pulses increment_id to the ID shower and tracks which ID bit has been captured.

Parameters:
- NUM_FRAME_BUFFER_PIXELS, 360*180, pixels per camera frame buffer.
- CNT_W, $clog2(NUM_FRAME_BUFFER_PIXELS), address width (localparam).
- PIXEL_WIDTH, 16, camera pixel word width.
- THRESHOLD, 16'hFFF0, a pixel is lit iff pixel > THRESHOLD (unsigned).
- LED_ADDRESS_WIDTH, 10, LED ID width minus 1; NUM_BITS = LED_ADDRESS_WIDTH+1 sweeps per calibration.
- SETTLE_FRAMES, 2, camera_frame_done pulses to wait before sweeping (>=1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- calibration_on  in  1  calibration mode enable.
- start_capture  in  1  single-cycle user capture request.
- displayed_frame_valid  in  1  ID shower reports the strand shows the current bit.
- camera_frame_done  in  1  single-cycle pulse at end of each camera frame write.
- fb_read_addr  out  CNT_W  camera frame-buffer read address.
- fb_read_data  in  PIXEL_WIDTH  read data; valid exactly 2 cycles after fb_read_addr.
- frame_buffer_in_address  out  CNT_W  pixel address to calibration manager.
- frame_buffer_data  out  1  thresholded pixel bit.
- new_frame_address  out  1  strobe: address/data valid this cycle.
- increment_id  out  1  single-cycle pulse advancing the ID shower bit.
- bit_index  out  LED_ADDRESS_WIDTH+1  number of bits captured so far.
- busy  out  1  high in any state other than IDLE and DONE.
- cal_done  out  1  high once all NUM_BITS sweeps complete.

Behaviour:
- Reset: every output is 0, FSM in IDLE, all counters 0.
- States: IDLE, WAIT_SHOWN, SETTLE, SWEEP, DRAIN, ADVANCE, DONE.
- IDLE -> WAIT_SHOWN on start_capture && calibration_on. start_capture is ignored in every other state.
- WAIT_SHOWN:
  - Entered from IDLE: advance when displayed_frame_valid is high (level).
  - Entered from ADVANCE: advance only on a rising edge of displayed_frame_valid, so a stale valid is ignored.
  - Then -> SETTLE with the settle counter at 0.
- SETTLE: count camera_frame_done pulses; the cycle the count reaches SETTLE_FRAMES, go to SWEEP with the address counter at 0.
- SWEEP: fb_read_addr = counter, counter +1 per cycle; after issuing NUM_FRAME_BUFFER_PIXELS-1, go to DRAIN.
- DRAIN: 3 cycles, flushing the read pipeline, then -> ADVANCE.
- Output pipeline:
  - Address A is issued in cycle t.
  - Outputs are registered: new_frame_address=1, frame_buffer_in_address=A, frame_buffer_data=(fb_read_data>THRESHOLD), all in cycle t+3.
  - Exactly NUM_FRAME_BUFFER_PIXELS strobes per sweep, addresses strictly ascending 0..N-1, no gaps.
- ADVANCE: increment_id=1 for exactly one cycle and bit_index += 1 in the same cycle.
  - If the new bit_index == NUM_BITS -> DONE, else -> IDLE (see Optional Feature).
- DONE: cal_done=1, holds until calibration_on falls.
- fb_read_addr holds its last value outside SWEEP. new_frame_address is 0 outside the pipeline tail.
- calibration_on low in any state: next cycle FSM -> IDLE, bit_index=0, cal_done=0, pipeline strobes killed (no further new_frame_address), no increment_id.
- camera_frame_done is ignored outside SETTLE; SWEEP does not wait on it.
- The address counter never wraps: the sweep stops at N-1, so non-power-of-2 N is safe.
- Async reset mid-sweep: all outputs drop to 0 immediately; no partial-sweep state is retained.

Optional Feature:
- Macro CAL_SWEEP_AUTO_RUN_EN.
- Defined: ADVANCE with bit_index < NUM_BITS goes directly to WAIT_SHOWN (edge-qualified). One start_capture runs all NUM_BITS sweeps.
- Undefined: ADVANCE returns to IDLE, and each bit needs a new start_capture.

Test Plan:
- Params N=16, SETTLE_FRAMES=2, LED_ADDRESS_WIDTH=2, macro undefined.
  - Stimulus: start_capture with displayed_frame_valid=1, two camera_frame_done pulses.
  - Response: 16 strobes, addresses 0..15, each 3 cycles after its fb_read_addr; then one increment_id pulse; bit_index=1; busy=0.
- Threshold: memory holds FFF0 at addr 3, FFF1 at addr 4, 0000 elsewhere -> frame_buffer_data=1 only at address 4.
- Three start_capture sweeps -> bit_index=3, cal_done=1. A fourth start_capture gives no strobes. calibration_on low clears cal_done and bit_index.
- calibration_on dropped at the 5th SWEEP cycle -> at most 3 trailing strobes (addresses 2..4), no further strobes, no increment_id, bit_index=0.
- start_capture during SETTLE is ignored. camera_frame_done during SWEEP does not disturb the address sequence.
- Macro defined, displayed_frame_valid toggled low then high after each increment_id -> one start_capture yields 3 sweeps, 48 strobes, cal_done=1. With valid held high after ADVANCE, the FSM stalls in WAIT_SHOWN.
